// File: rtl/tb_mem_arbiter_pkg.sv
// Shared types for the bench-memory arbiter: request/memory-port payloads, FSM state and requester ids.
package tb_mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    typedef enum logic {
        cpu_data_acc_sz_8  = 1'b0,
        cpu_data_acc_sz_16 = 1'b1
    } cpu_data_acc_sz_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        cpu_data_acc_sz_t  acc_sz;
        logic              is_write;
    } tb_mem_req;

    typedef struct packed {
        logic [ADDR_W-1:0] read_addr_in;
        cpu_data_acc_sz_t  read_data_acc_sz;
        logic [ADDR_W-1:0] write_addr_in;
        logic [DATA_W-1:0] write_data_in;
        cpu_data_acc_sz_t  write_data_acc_sz;
        logic              write_data_we;
    } tb_mem_inputs;

    typedef enum logic {IDLE, ACCESS} tb_arb_state;
    typedef enum logic {A, B} tb_requester;

    // A 16-bit access at the top address would wrap past the end of memory.
    function automatic logic is_reject(input tb_mem_req r);
        return (r.acc_sz == cpu_data_acc_sz_16) && (r.addr == 16'hFFFF);
    endfunction

endpackage

// File: rtl/tb_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester that did not go last wins.
module tb_rr_pick2
    import tb_mem_arbiter_pkg::*;
(
    input  logic        req_a,
    input  logic        req_b,
    input  tb_requester last_owner,
    output logic        valid,
    output tb_requester winner
);

    always_comb begin
        valid  = req_a | req_b;
        winner = A;
        if (req_a && req_b) begin
            winner = (last_owner == A) ? B : A;
        end else if (req_b) begin
            winner = B;
        end
    end

endmodule

// File: rtl/tb_mem_arbiter.sv
// Shares the single tb_memory port between requesters A and B with round-robin and bounded lock bursts.
module tb_mem_arbiter
    import tb_mem_arbiter_pkg::*;
#(
    parameter int unsigned max_burst = 4
) (
    input  logic               write_clk,
    input  logic               reset,
    input  logic               req_a,
    input  logic               req_b,
    input  logic               lock_a,
    input  logic               lock_b,
    input  tb_mem_req          a_req,
    input  tb_mem_req          b_req,
    output logic               gnt_a,
    output logic               gnt_b,
    output logic               done_a,
    output logic               done_b,
    output logic               err_a,
    output logic               err_b,
    output logic [DATA_W-1:0]  rdata_a,
    output logic [DATA_W-1:0]  rdata_b,
    output tb_mem_inputs       mem_inputs,
    input  logic [DATA_W-1:0]  mem_read_data
);

    localparam int unsigned CNT_W = (max_burst > 1) ? $clog2(max_burst) : 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(max_burst - 1);

    tb_arb_state      state;
    tb_requester      owner;
    tb_requester      last_owner;
    logic [CNT_W-1:0] burst_cnt;
    tb_mem_req        cur;

    logic        pick_valid;
    tb_requester pick_winner;
    logic        reject;
    logic        own_req;
    logic        own_lock;
    tb_mem_req   own_fields;

    tb_rr_pick2 u_pick (
        .req_a      (req_a),
        .req_b      (req_b),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // Current owner's live request lines, used to decide whether a locked burst continues.
    always_comb begin
        reject     = is_reject(cur);
        own_req    = (owner == A) ? req_a  : req_b;
        own_lock   = (owner == A) ? lock_a : lock_b;
        own_fields = (owner == A) ? a_req  : b_req;
    end

    // Memory port is idle (all zero) outside ACCESS; reset kills the write strobe immediately.
    always_comb begin
        mem_inputs = '0;
        if (state == ACCESS) begin
            mem_inputs.read_addr_in      = cur.addr;
            mem_inputs.read_data_acc_sz  = cur.acc_sz;
            mem_inputs.write_addr_in     = cur.addr;
            mem_inputs.write_data_in     = cur.wdata;
            mem_inputs.write_data_acc_sz = cur.acc_sz;
            mem_inputs.write_data_we     = cur.is_write & ~reject & ~reset;
        end
    end

    always_ff @(posedge write_clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= A;
            last_owner <= B;
            burst_cnt  <= '0;
            cur        <= '0;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            done_a     <= 1'b0;
            done_b     <= 1'b0;
            err_a      <= 1'b0;
            err_b      <= 1'b0;
            rdata_a    <= '0;
            rdata_b    <= '0;
        end else begin
            done_a <= 1'b0;
            done_b <= 1'b0;
            err_a  <= 1'b0;
            err_b  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state      <= ACCESS;
                        owner      <= pick_winner;
                        last_owner <= pick_winner;
                        burst_cnt  <= '0;
                        cur        <= (pick_winner == A) ? a_req : b_req;
                        gnt_a      <= (pick_winner == A);
                        gnt_b      <= (pick_winner == B);
                    end
                end
                ACCESS: begin
                    if (owner == A) begin
                        done_a <= 1'b1;
                        err_a  <= reject;
                        if (!cur.is_write && !reject) rdata_a <= mem_read_data;
                    end else begin
                        done_b <= 1'b1;
                        err_b  <= reject;
                        if (!cur.is_write && !reject) rdata_b <= mem_read_data;
                    end
                    // Burst continues with freshly captured fields; otherwise return to arbitration.
                    if (own_lock && own_req && (burst_cnt < BURST_LAST)) begin
                        cur       <= own_fields;
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end else begin
                        state <= IDLE;
                        gnt_a <= 1'b0;
                        gnt_b <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Directed bench for tb_mem_arbiter with a behavioural tb_memory and a done-driven scoreboard.
module tb_tb_mem_arbiter;
    import tb_mem_arbiter_pkg::*;

    logic         write_clk = 1'b0;
    logic         reset     = 1'b1;
    logic         req_a     = 1'b0;
    logic         req_b     = 1'b0;
    logic         lock_a    = 1'b0;
    logic         lock_b    = 1'b0;
    tb_mem_req    a_req     = '0;
    tb_mem_req    b_req     = '0;
    logic         gnt_a, gnt_b, done_a, done_b, err_a, err_b;
    logic [15:0]  rdata_a, rdata_b;
    tb_mem_inputs mem_inputs;
    logic [15:0]  mem_read_data;

    tb_mem_arbiter #(.max_burst(4)) dut (
        .write_clk     (write_clk),
        .reset         (reset),
        .req_a         (req_a),
        .req_b         (req_b),
        .lock_a        (lock_a),
        .lock_b        (lock_b),
        .a_req         (a_req),
        .b_req         (b_req),
        .gnt_a         (gnt_a),
        .gnt_b         (gnt_b),
        .done_a        (done_a),
        .done_b        (done_b),
        .err_a         (err_a),
        .err_b         (err_b),
        .rdata_a       (rdata_a),
        .rdata_b       (rdata_b),
        .mem_inputs    (mem_inputs),
        .mem_read_data (mem_read_data)
    );

    always #5 write_clk = ~write_clk;

    // Behavioural memory: little-endian bytes, asynchronous read, write on the clock edge.
    logic [7:0]  mem [0:65535];
    logic [15:0] rd_hi;
    logic [15:0] wr_hi;
    int          we_cnt = 0;

    assign rd_hi = mem_inputs.read_addr_in + 16'd1;
    assign wr_hi = mem_inputs.write_addr_in + 16'd1;
    assign mem_read_data = (mem_inputs.read_data_acc_sz == cpu_data_acc_sz_16)
                         ? {mem[rd_hi], mem[mem_inputs.read_addr_in]}
                         : {8'h00, mem[mem_inputs.read_addr_in]};

    always @(posedge write_clk) begin
        if (mem_inputs.write_data_we) begin
            mem[mem_inputs.write_addr_in] <= mem_inputs.write_data_in[7:0];
            if (mem_inputs.write_data_acc_sz == cpu_data_acc_sz_16)
                mem[wr_hi] <= mem_inputs.write_data_in[15:8];
            we_cnt <= we_cnt + 1;
        end
    end

    typedef struct {
        logic        is_b;
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_done(input logic is_b, input logic err, input logic [15:0] rd);
        exp_t e;
        e.is_b  = is_b;
        e.err   = err;
        e.rdata = rd;
        exp_q.push_back(e);
    endtask

    function automatic tb_mem_req mk(input logic [15:0] addr, input logic [15:0] wdata,
                                     input logic sz16, input logic w);
        tb_mem_req r;
        r.addr     = addr;
        r.wdata    = wdata;
        r.acc_sz   = sz16 ? cpu_data_acc_sz_16 : cpu_data_acc_sz_8;
        r.is_write = w;
        return r;
    endfunction

    task automatic tick();
        @(posedge write_clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_gnt"},   32'({gnt_a, gnt_b}), 32'd0);
        chk({tag, "_done"},  32'({done_a, done_b}), 32'd0);
        chk({tag, "_err"},   32'({err_a, err_b}), 32'd0);
        chk({tag, "_rdata"}, {rdata_a, rdata_b}, 32'd0);
        chk({tag, "_mem_inputs_zero"}, 32'(mem_inputs != '0), 32'd0);
    endtask

    // Monitor: exclusivity every cycle, and each done pops one scoreboard entry.
    always @(negedge write_clk) begin
        chk("gnt_exclusive", 32'(gnt_a & gnt_b), 32'd0);
        if (done_a || done_b) begin
            chk("done_exclusive", 32'(done_a & done_b), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'({done_a, done_b}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_owner_is_b", 32'(done_b), 32'(mon_e.is_b));
                chk("err", 32'(mon_e.is_b ? err_b : err_a), 32'(mon_e.err));
                chk("rdata", 32'(mon_e.is_b ? rdata_b : rdata_a), 32'(mon_e.rdata));
            end
        end else begin
            chk("err_without_done", 32'(err_a | err_b), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        bit [0:7] ga2;
        bit [0:7] gb2;
        bit [0:9] ga3;
        bit [0:9] gb3;
        int       we0;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        chk_reset("rst");

        // Single 16-bit write then read by A.
        a_req = mk(16'h0100, 16'hBEEF, 1'b1, 1'b1);
        req_a = 1'b1;
        expect_done(1'b0, 1'b0, 16'h0000);
        tick();
        chk("t1_wr_gnt_a", 32'(gnt_a), 32'd1);
        chk("t1_wr_gnt_b", 32'(gnt_b), 32'd0);
        chk("t1_wr_we", 32'(mem_inputs.write_data_we), 32'd1);
        req_a = 1'b0;
        tick();
        chk("t1_gnt_a_drop", 32'(gnt_a), 32'd0);
        a_req = mk(16'h0100, 16'h0000, 1'b1, 1'b0);
        req_a = 1'b1;
        expect_done(1'b0, 1'b0, 16'hBEEF);
        tick();
        chk("t1_rd_gnt_a", 32'(gnt_a), 32'd1);
        req_a = 1'b0;
        repeat (2) tick();
        chk("t1_mem_lo", 32'(mem[16'h0100]), 32'h00EF);
        chk("t1_mem_hi", 32'(mem[16'h0101]), 32'h00BE);

        // Ties after reset alternate A, B, A, B.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset("t2_rst");
        a_req = mk(16'h0100, 16'h0000, 1'b1, 1'b0);
        b_req = mk(16'h0100, 16'h0000, 1'b0, 1'b0);
        req_a = 1'b1;
        req_b = 1'b1;
        expect_done(1'b0, 1'b0, 16'hBEEF);
        expect_done(1'b1, 1'b0, 16'h00EF);
        expect_done(1'b0, 1'b0, 16'hBEEF);
        expect_done(1'b1, 1'b0, 16'h00EF);
        ga2 = 8'b1000_1000;
        gb2 = 8'b0010_0010;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("t2_gnt_a_c%0d", i + 1), 32'(gnt_a), 32'(ga2[i]));
            chk($sformatf("t2_gnt_b_c%0d", i + 1), 32'(gnt_b), 32'(gb2[i]));
            if (i == 6) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
        end
        tick();

        // Locked burst by B interleaved with one pending read by A.
        b_req  = mk(16'h0200, 16'h0011, 1'b0, 1'b1);
        req_b  = 1'b1;
        lock_b = 1'b1;
        for (int k = 0; k < 4; k++) expect_done(1'b1, 1'b0, 16'h00EF);
        expect_done(1'b0, 1'b0, 16'h0011);
        for (int k = 0; k < 2; k++) expect_done(1'b1, 1'b0, 16'h00EF);
        ga3 = 10'b00000_10000;
        gb3 = 10'b11110_00110;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("t3_gnt_a_c%0d", i + 1), 32'(gnt_a), 32'(ga3[i]));
            chk($sformatf("t3_gnt_b_c%0d", i + 1), 32'(gnt_b), 32'(gb3[i]));
            case (i)
                0: begin
                    b_req = mk(16'h0201, 16'h0022, 1'b0, 1'b1);
                    a_req = mk(16'h0200, 16'h0000, 1'b0, 1'b0);
                    req_a = 1'b1;
                end
                1: b_req = mk(16'h0202, 16'h0033, 1'b0, 1'b1);
                2: b_req = mk(16'h0203, 16'h0044, 1'b0, 1'b1);
                3: b_req = mk(16'h0204, 16'h0055, 1'b0, 1'b1);
                5: req_a = 1'b0;
                7: b_req = mk(16'h0205, 16'h0066, 1'b0, 1'b1);
                8: begin
                    req_b  = 1'b0;
                    lock_b = 1'b0;
                end
                default: ;
            endcase
        end
        tick();
        chk("t3_mem_0200", 32'(mem[16'h0200]), 32'h11);
        chk("t3_mem_0201", 32'(mem[16'h0201]), 32'h22);
        chk("t3_mem_0202", 32'(mem[16'h0202]), 32'h33);
        chk("t3_mem_0203", 32'(mem[16'h0203]), 32'h44);
        chk("t3_mem_0204", 32'(mem[16'h0204]), 32'h55);
        chk("t3_mem_0205", 32'(mem[16'h0205]), 32'h66);

        // Rejected 16-bit write and read at the top address; 8-bit there is legal.
        we0   = we_cnt;
        a_req = mk(16'hFFFF, 16'h1234, 1'b1, 1'b1);
        req_a = 1'b1;
        expect_done(1'b0, 1'b1, 16'h0011);
        tick();
        chk("t4_gnt_a", 32'(gnt_a), 32'd1);
        chk("t4_we_off", 32'(mem_inputs.write_data_we), 32'd0);
        req_a = 1'b0;
        repeat (2) tick();
        a_req = mk(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        req_a = 1'b1;
        expect_done(1'b0, 1'b1, 16'h0011);
        tick();
        req_a = 1'b0;
        repeat (2) tick();
        chk("t4_mem_ffff", 32'(mem[16'hFFFF]), 32'h00);
        chk("t4_mem_0000", 32'(mem[16'h0000]), 32'h00);
        chk("t4_no_we", 32'(we_cnt - we0), 32'd0);
        b_req = mk(16'hFFFF, 16'h005A, 1'b0, 1'b1);
        req_b = 1'b1;
        expect_done(1'b1, 1'b0, 16'h00EF);
        tick();
        chk("t4_b_gnt", 32'(gnt_b), 32'd1);
        req_b = 1'b0;
        repeat (2) tick();
        chk("t4_mem_ffff_byte", 32'(mem[16'hFFFF]), 32'h5A);
        chk("t4_one_we", 32'(we_cnt - we0), 32'd1);

        // Reset during A's write cycle: strobe gated, no done.
        a_req = mk(16'h0300, 16'h00AA, 1'b0, 1'b1);
        req_a = 1'b1;
        tick();
        chk("t5_gnt_a", 32'(gnt_a), 32'd1);
        chk("t5_we_before_reset", 32'(mem_inputs.write_data_we), 32'd1);
        req_a = 1'b0;
        reset = 1'b1;
        #1;
        chk("t5_we_gated", 32'(mem_inputs.write_data_we), 32'd0);
        tick();
        reset = 1'b0;
        chk_reset("t5_rst");
        chk("t5_mem_0300", 32'(mem[16'h0300]), 32'h00);
        repeat (3) tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tb_mem_arbiter.md
# tb_mem_arbiter

Two-requester arbiter that shares the single port of `tb_memory` between requester A (the CPU under test) and requester B (a bench loader or monitor). It captures one request per grant, drives the `tb_mem_inputs` struct for exactly one access cycle, and returns read data with a registered `done` pulse. A round-robin policy with bounded lock bursts gives fair back-to-back access.

## Interface
- `max_burst`, default 4: maximum consecutive locked accesses by one owner before arbitration is forced.
- `write_clk`  in  1  clock; the memory write clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_a`, `req_b`  in  1  request valid.
- `lock_a`, `lock_b`  in  1  request a back-to-back access after the current one.
- `a_req`, `b_req`  in  `tb_mem_req`  request fields: `addr` [15:0], `wdata` [15:0], `acc_sz` (`cpu_data_acc_sz_8`/16), `is_write`.
- `gnt_a`, `gnt_b`  out  1  high during the owner's access cycle.
- `done_a`, `done_b`  out  1  one-cycle pulse, the cycle after the access.
- `err_a`, `err_b`  out  1  pulses together with `done` when the request was rejected.
- `rdata_a`, `rdata_b`  out  16  read result, valid while `done` is high, held until the next read.
- `mem_inputs`  out  `tb_mem_inputs`  connects to `tb_memory.the_inputs`.
- `mem_read_data`  in  16  from `tb_memory.read_data_out` (asynchronous read).

## Operation
- **States:** IDLE and ACCESS. Registers: `owner`, `last_owner`, `burst_cnt`, and the captured request `cur`.
- **IDLE:** if any `req` is high, pick a winner, capture its request fields into `cur`, set `owner`, `last_owner` = winner, `burst_cnt` = 0, and go to ACCESS.
  - Only one requester: it wins.
  - Both: the requester that is not `last_owner` wins.
- **ACCESS:**
  - `gnt_owner` = 1. `mem_inputs` is driven from `cur`.
  - Reads: `read_addr_in` = `cur.addr`, `read_data_acc_sz` = `cur.acc_sz`.
  - Writes: `write_addr_in`, `write_data_in`, `write_data_acc_sz` from `cur`, and `write_data_we` = `cur.is_write & ~reject & ~reset`.
  - At the closing edge: `rdata_owner` ← `mem_read_data` if this is a read and not rejected. `done_owner` ← 1. `err_owner` ← `reject`.
- **Leaving ACCESS:** if `lock_owner & req_owner` and `burst_cnt` < `max_burst`-1, capture the owner's new fields, increment `burst_cnt`, and stay in ACCESS. Otherwise go to IDLE.
- **Reject:** `cur.acc_sz` = 16 with `cur.addr` = 16'hFFFF. No write is performed, `rdata` is unchanged, and `err` pulses.
- **Outside ACCESS:** all `mem_inputs` fields are 0 and `we` = 0.
- **Requester rule:** hold `req` and the request fields stable until `gnt` is seen high. Fields are captured on the edge that enters ACCESS (or continues a locked burst).

## Timing
- **Reset values:** state IDLE, `last_owner` = B (so A wins the first tie), `gnt`/`done`/`err` = 0, `rdata` = 0, `burst_cnt` = 0, `mem_inputs` = 0.
- **Reset mid-ACCESS:** `we` is gated off in the reset cycle, so no write lands. No `done` is issued.
- **Latency:** `req` sampled at edge N → `gnt` in cycle N+1 → `done`/`rdata` in cycle N+2.
- **Throughput:** unlocked, one access per 2 cycles per requester. Locked, one per cycle for up to `max_burst` accesses, then at least one IDLE cycle.
- **Simultaneous events:** a requester that asserts `req` during the other's ACCESS is served at the next IDLE decision. `done` of access k coincides with `gnt` of access k+1 during a burst.
- `gnt_a` and `gnt_b` are never high together. Likewise `done_a` and `done_b`.

## Structure
- **Shared package** (`pkg_cpu` or a new `pkg_tb`): `tb_mem_req` struct, `tb_mem_inputs` struct (moved out of the memory file), the `tb_arb_state` enum {IDLE, ACCESS}, and the requester enum {A, B}.
- **Sub-module:** `tb_rr_pick2`, a combinational 2-way round-robin picker with inputs (`req_a`, `req_b`, `last_owner`) and outputs (`valid`, `winner`).

## Test plan
- **Single write then read by A:** write 16-bit 16'hBEEF at 16'h0100, then read it. Expect `gnt_a` one cycle after each `req`. The second `done_a` shows `rdata_a` = 16'hBEEF.
- **Simultaneous requests after reset:** `req_a` and `req_b` in the same cycle. Expect A granted first, B granted 2 cycles later. A repeat tie goes to the other requester, alternating A, B, A, B.
- **Locked burst:** `max_burst` = 4. B holds `lock_b`/`req_b` and writes bytes 8'h11..8'h66 to 16'h0200.. . Expect `gnt_b` for 4 consecutive cycles, then an IDLE cycle, then the remaining two. A's pending request is served in that IDLE decision before B's 5th access.
- **Reject:** 16-bit write of 16'h1234 at 16'hFFFF. Expect `err` pulsing with `done`, memory unchanged, and `we` never high.
- **Reset mid-ACCESS:** assert `reset` during A's write cycle of 8'hAA to 16'h0300. Expect no write (memory still 0), no `done_a`, and all outputs 0 on the next cycle.
